// File: rtl/uart_pkg.sv
// uart_pkg: parity mode constants, 3-bit transmitter state encoding and baud divisor helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks, held at phase zero while restart is high
module uart_baud_tick #(
  parameter int DIV = 1085
) (
  input logic clk,
  input logic rst,
  input logic restart,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || restart || tick) ? '0 : cnt + CW'(1);
  assign tick = cnt == CW'(DIV - 1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: configurable UART transmitter with valid/ready input; define UART_TX_GAP_EN to enforce GAP_CYCLES idle clocks between frames
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int GAP_CYCLES = 0
) (
  input logic clk,
  input logic rst,
  input logic [DATA_BITS-1:0] tx_data,
  input logic tx_valid,
  output logic tx_ready,
  output logic tx_busy,
  output logic uart_tx,
  output logic led
);
  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: BAUD_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("uart_tx_frame: GAP_CYCLES must not be negative");
  end
  state_t state;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] bit_idx;
  logic par_bit;
  logic tick;
  logic gap_done;
  uart_baud_tick #(.DIV(BAUD_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .restart(state == IDLE),
    .tick(tick)
  );
`ifdef UART_TX_GAP_EN
  localparam bit GAP_ON = GAP_CYCLES > 1;
  localparam int GW = GAP_CYCLES > 2 ? $clog2(GAP_CYCLES - 1) : 1;
  logic [GW-1:0] gap_cnt;
  always_ff @(posedge clk) gap_cnt <= (rst || state != GAP) ? '0 : gap_cnt + GW'(1);
  assign gap_done = gap_cnt == GW'(GAP_CYCLES - 2);
`else
  localparam bit GAP_ON = 1'b0;
  assign gap_done = 1'b1;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
      uart_tx <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy <= 1'b0;
      led <= 1'b0;
    end else
      case (state)
        IDLE:
          if (tx_valid && tx_ready) begin
            shreg <= tx_data;
            par_bit <= (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
            bit_idx <= '0;
            uart_tx <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy <= 1'b1;
            state <= START;
          end else
            tx_ready <= 1'b1;
        START:
          if (tick) begin
            uart_tx <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        DATA:
          if (tick && bit_idx == 4'(DATA_BITS - 1)) begin
            bit_idx <= '0;
            uart_tx <= (PARITY != PARITY_NONE) ? par_bit : 1'b1;
            state <= (PARITY != PARITY_NONE) ? PAR : STOP;
          end else if (tick) begin
            bit_idx <= bit_idx + 4'd1;
            uart_tx <= shreg[0];
            shreg <= shreg >> 1;
          end
        PAR:
          if (tick) begin
            uart_tx <= 1'b1;
            state <= STOP;
          end
        STOP:
          if (tick && bit_idx == 4'(STOP_BITS - 1)) begin
            bit_idx <= '0;
            led <= ~led;
            tx_busy <= 1'b0;
            tx_ready <= !GAP_ON;
            state <= GAP_ON ? GAP : IDLE;
          end else if (tick)
            bit_idx <= bit_idx + 4'd1;
        GAP:
          if (gap_done) begin
            tx_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule
